// File: rtl/wb_port_arbiter.sv
// Write-port arbiter for the 32x32 data register file.
// The pipeline always owns the port when it writes. Multiplier results that
// lose arbitration wait in an in-order circular buffer and drain on idle
// port cycles. A stall request is raised when the buffer approaches full or
// when ID reads a register whose multiplier result is still pending.
module wb_port_arbiter #(
    parameter int DEPTH       = 8,
    parameter int MULT_STAGES = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we_i,
    input  logic [4:0]               pipe_addr_i,
    input  logic [31:0]              pipe_data_i,
    input  logic                     mult_valid_i,
    input  logic [4:0]               mult_addr_i,
    input  logic [31:0]              mult_data_i,
    input  logic                     rs1_re_i,
    input  logic [4:0]               rs1_addr_i,
    input  logic                     rs2_re_i,
    input  logic [4:0]               rs2_addr_i,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [31:0]              rf_wdata_o,
    output logic                     stall_req_o,
    output logic [1:0]               rs_pend_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0] FULL_LEVEL  = CW'(DEPTH);
    localparam logic [AW:0] STALL_LEVEL = CW'(DEPTH - MULT_STAGES);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       entryAddr_q [DEPTH];
    logic [31:0]      entryData_q [DEPTH];
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;

    logic pipeNz;
    logic multLive;
    logic bufEmpty;
    logic bufFull;
    logic popEn;
    logic bypassEn;
    logic pushReq;
    logic pushEn;
    logic ovfSet;
    logic multPend;
    logic rs1BufHit;
    logic rs2BufHit;

    // Decide who owns the port and whether the buffer pushes, pops or overflows.
    always_comb begin
        pipeNz   = pipe_we_i && (pipe_addr_i != 5'd0);
        multLive = mult_valid_i && (mult_addr_i != 5'd0) &&
                   !(pipeNz && (pipe_addr_i == mult_addr_i));
        bufEmpty = (count_q == '0);
        bufFull  = (count_q == FULL_LEVEL);
        popEn    = !pipe_we_i && !bufEmpty;
        bypassEn = !pipe_we_i && bufEmpty && multLive;
        pushReq  = multLive && !bypassEn;
        pushEn   = pushReq && (!bufFull || popEn);
        ovfSet   = pushReq && bufFull && !popEn;
    end

    // Drive the register file write port from the winning source.
    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (pipe_we_i) begin
            rf_we_o    = pipeNz;
            rf_waddr_o = pipe_addr_i;
            rf_wdata_o = pipe_data_i;
        end else if (popEn) begin
            if (valid_q[head_q]) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = entryAddr_q[head_q];
                rf_wdata_o = entryData_q[head_q];
            end
        end else if (bypassEn) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = mult_addr_i;
            rf_wdata_o = mult_data_i;
        end
    end

    // Flag ID reads of registers that still have a multiplier result in flight.
    always_comb begin
        rs1BufHit = 1'b0;
        rs2BufHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entryAddr_q[i] == rs1_addr_i)) rs1BufHit = 1'b1;
            if (valid_q[i] && (entryAddr_q[i] == rs2_addr_i)) rs2BufHit = 1'b1;
        end
        multPend     = mult_valid_i && !bypassEn;
        rs_pend_o[0] = rs1_re_i && (rs1_addr_i != 5'd0) &&
                       (rs1BufHit || (multPend && (mult_addr_i == rs1_addr_i)));
        rs_pend_o[1] = rs2_re_i && (rs2_addr_i != 5'd0) &&
                       (rs2BufHit || (multPend && (mult_addr_i == rs2_addr_i)));
        stall_req_o  = (count_q >= STALL_LEVEL) || (rs_pend_o != 2'b00);
    end

    // Compute next buffer bookkeeping; a newer pipeline write kills stale entries.
    always_comb begin
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q | ovfSet;
        if (popEn) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + AW'(1);
        end
        if (pipeNz) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entryAddr_q[i] == pipe_addr_i) valid_d[i] = 1'b0;
            end
        end
        if (pushEn) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + AW'(1);
        end
        count_d = count_q + CW'(pushEn) - CW'(popEn);
    end

    // Register buffer control state; reset discards everything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Capture the payload of a pushed result; valid bits decide if it matters.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            entryAddr_q[tail_q] <= mult_addr_i;
            entryData_q[tail_q] <= mult_data_i;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: a queue-based model of the result buffer
// is checked against the DUT every cycle, plus directed literal checks.
module tb_wb_port_arbiter;

    localparam int DEPTH       = 8;
    localparam int MULT_STAGES = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_we_i = 1'b0;
    logic [4:0]  pipe_addr_i = '0;
    logic [31:0] pipe_data_i = '0;
    logic        mult_valid_i = 1'b0;
    logic [4:0]  mult_addr_i = '0;
    logic [31:0] mult_data_i = '0;
    logic        rs1_re_i = 1'b0;
    logic [4:0]  rs1_addr_i = '0;
    logic        rs2_re_i = 1'b0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        stall_req_o;
    logic [1:0]  rs_pend_o;
    logic [3:0]  count_o;
    logic        overflow_o;

    typedef struct packed {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
    } entry_t;

    entry_t      modelQ[$];
    logic        modelOvf = 1'b0;
    logic [31:0] rfShadow [32];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .MULT_STAGES(MULT_STAGES)) dut (
        .clk(clk), .rst(rst),
        .pipe_we_i(pipe_we_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
        .mult_valid_i(mult_valid_i), .mult_addr_i(mult_addr_i), .mult_data_i(mult_data_i),
        .rs1_re_i(rs1_re_i), .rs1_addr_i(rs1_addr_i),
        .rs2_re_i(rs2_re_i), .rs2_addr_i(rs2_addr_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .stall_req_o(stall_req_o), .rs_pend_o(rs_pend_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    // Compare one observed value against its expectation and tally the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs just after a rising edge and let them settle.
    task automatic applyStimulus(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                 input logic r1e, input logic [4:0] r1a,
                                 input logic r2e, input logic [4:0] r2a);
        @(posedge clk);
        #1;
        pipe_we_i    = pwe;
        pipe_addr_i  = pa;
        pipe_data_i  = pd;
        mult_valid_i = mv;
        mult_addr_i  = ma;
        mult_data_i  = md;
        rs1_re_i     = r1e;
        rs1_addr_i   = r1a;
        rs2_re_i     = r2e;
        rs2_addr_i   = r2a;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // True when a read of addr must wait for a multiplier result not yet written.
    function automatic logic modelPending(input logic re, input logic [4:0] addr,
                                          input logic bypassed);
        logic hit;
        hit = 1'b0;
        if (re && addr != 5'd0) begin
            foreach (modelQ[i]) if (modelQ[i].v && modelQ[i].a == addr) hit = 1'b1;
            if (mult_valid_i && !bypassed && mult_addr_i == addr) hit = 1'b1;
        end
        return hit;
    endfunction

    // Every falling edge: predict outputs from the model, compare, then advance the model.
    initial begin : compareProc
        logic        pNz, mLive, ePop, eBypass, ePush, eOvf, eWe, checkAddr, pushReq, eStall;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        logic [1:0]  ePend;
        int          qSize;
        forever begin
            @(negedge clk);
            if (rst) begin
                modelQ.delete();
                modelOvf = 1'b0;
            end else begin
                pNz   = pipe_we_i && pipe_addr_i != 5'd0;
                mLive = mult_valid_i && mult_addr_i != 5'd0 &&
                        !(pNz && pipe_addr_i == mult_addr_i);
                qSize = modelQ.size();
                ePop = 1'b0; eBypass = 1'b0; eWe = 1'b0;
                eAddr = 5'd0; eData = 32'd0; checkAddr = 1'b0;
                if (pipe_we_i) begin
                    eWe = pNz; eAddr = pipe_addr_i; eData = pipe_data_i; checkAddr = pNz;
                end else if (qSize > 0) begin
                    ePop = 1'b1; eWe = modelQ[0].v; eAddr = modelQ[0].a;
                    eData = modelQ[0].d; checkAddr = modelQ[0].v;
                end else if (mLive) begin
                    eBypass = 1'b1; eWe = 1'b1; eAddr = mult_addr_i;
                    eData = mult_data_i; checkAddr = 1'b1;
                end else begin
                    checkAddr = 1'b1;
                end
                pushReq  = mLive && !eBypass;
                ePush    = pushReq && (qSize < DEPTH || ePop);
                eOvf     = pushReq && !ePush;
                ePend[0] = modelPending(rs1_re_i, rs1_addr_i, eBypass);
                ePend[1] = modelPending(rs2_re_i, rs2_addr_i, eBypass);
                eStall   = (qSize >= DEPTH - MULT_STAGES) || (ePend != 2'b00);

                checkOutput("cyc_we", 32'(rf_we_o), 32'(eWe));
                if (checkAddr) begin
                    checkOutput("cyc_waddr", 32'(rf_waddr_o), 32'(eAddr));
                    checkOutput("cyc_wdata", rf_wdata_o, eData);
                end
                checkOutput("cyc_stall", 32'(stall_req_o), 32'(eStall));
                checkOutput("cyc_pend", 32'(rs_pend_o), 32'(ePend));
                checkOutput("cyc_count", 32'(count_o), 32'(qSize));
                checkOutput("cyc_overflow", 32'(overflow_o), 32'(modelOvf));

                if (rf_we_o) rfShadow[rf_waddr_o] = rf_wdata_o;

                if (ePop) void'(modelQ.pop_front());
                if (pNz) foreach (modelQ[i]) if (modelQ[i].a == pipe_addr_i) modelQ[i].v = 1'b0;
                if (ePush) modelQ.push_back(entry_t'({1'b1, mult_addr_i, mult_data_i}));
                if (eOvf) modelOvf = 1'b1;
            end
        end
    end

    // Directed scenarios with hand-computed expectations.
    initial begin : stimulusProc
        for (int r = 0; r < 32; r++) rfShadow[r] = 32'd0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_we", 32'(rf_we_o), 32'd0);
        checkOutput("reset_count", 32'(count_o), 32'd0);
        checkOutput("reset_stall", 32'(stall_req_o), 32'd0);
        checkOutput("reset_pend", 32'(rs_pend_o), 32'd0);
        checkOutput("reset_overflow", 32'(overflow_o), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] bypass of idle port");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("bypass_we", 32'(rf_we_o), 32'd1);
        checkOutput("bypass_waddr", 32'(rf_waddr_o), 32'd5);
        checkOutput("bypass_wdata", rf_wdata_o, 32'h12345678);
        checkOutput("bypass_count", 32'(count_o), 32'd0);
        idleCycle();
        checkOutput("bypass_count_after", 32'(count_o), 32'd0);

        $display("[TB] conflict then drain");
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("conflict_waddr", 32'(rf_waddr_o), 32'd3);
        checkOutput("conflict_wdata", rf_wdata_o, 32'h33);
        idleCycle();
        checkOutput("drain_waddr", 32'(rf_waddr_o), 32'd7);
        checkOutput("drain_wdata", rf_wdata_o, 32'h77);
        checkOutput("drain_count", 32'(count_o), 32'd1);
        idleCycle();
        checkOutput("drain_count_empty", 32'(count_o), 32'd0);
        checkOutput("drain_we_empty", 32'(rf_we_o), 32'd0);

        $display("[TB] burst fill and in-order drain");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(10 + i), 32'(32'hA00 + i), 1'b1, 5'(20 + i), 32'(32'h100 + i),
                          1'b0, 5'd0, 1'b0, 5'd0);
            checkOutput("burst_count", 32'(count_o), 32'(i));
            checkOutput("burst_stall", 32'(stall_req_o), 32'(i >= 5));
        end
        for (int j = 0; j < 6; j++) begin
            idleCycle();
            checkOutput("burst_drain_waddr", 32'(rf_waddr_o), 32'(20 + j));
            checkOutput("burst_drain_wdata", rf_wdata_o, 32'(32'h100 + j));
            checkOutput("burst_drain_count", 32'(count_o), 32'(6 - j));
            checkOutput("burst_drain_stall", 32'(stall_req_o), 32'((6 - j) >= 5));
        end
        idleCycle();
        checkOutput("burst_empty", 32'(count_o), 32'd0);

        $display("[TB] WAW invalidation");
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hAA, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd9, 32'hBB, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("waw_waddr", 32'(rf_waddr_o), 32'd9);
        checkOutput("waw_wdata", rf_wdata_o, 32'hBB);
        checkOutput("waw_count", 32'(count_o), 32'd1);
        idleCycle();
        checkOutput("waw_dead_pop_we", 32'(rf_we_o), 32'd0);
        checkOutput("waw_dead_pop_count", 32'(count_o), 32'd1);
        idleCycle();
        checkOutput("waw_empty", 32'(count_o), 32'd0);
        checkOutput("waw_final_x9", rfShadow[9], 32'hBB);
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd5, 32'h66, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("waw_same_cycle_wdata", rf_wdata_o, 32'h55);
        idleCycle();
        checkOutput("waw_same_cycle_count", 32'(count_o), 32'd0);

        $display("[TB] x0 discards");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("x0_mult_we", 32'(rf_we_o), 32'd0);
        applyStimulus(1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("x0_pipe_we", 32'(rf_we_o), 32'd0);
        checkOutput("x0_count", 32'(count_o), 32'd0);

        $display("[TB] read hazards");
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 1'b1, 5'd0);
        checkOutput("hz_pend_rs1", 32'(rs_pend_o), 32'b01);
        checkOutput("hz_stall_rs1", 32'(stall_req_o), 32'd1);
        applyStimulus(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd6);
        checkOutput("hz_pend_both", 32'(rs_pend_o), 32'b11);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd6);
        checkOutput("hz_write_x4", 32'(rf_waddr_o), 32'd4);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd6);
        checkOutput("hz_pend_rs2_only", 32'(rs_pend_o), 32'b10);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd6);
        checkOutput("hz_pend_clear", 32'(rs_pend_o), 32'b00);
        checkOutput("hz_stall_clear", 32'(stall_req_o), 32'd0);
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC, 1'b0, 5'd0, 1'b1, 5'd12);
        checkOutput("hz_incoming_mult", 32'(rs_pend_o), 32'b10);
        idleCycle();
        idleCycle();

        $display("[TB] overflow and async reset");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'd1, 32'(i), 1'b1, 5'(16 + i), 32'(32'hF00 + i),
                          1'b0, 5'd0, 1'b0, 5'd0);
            checkOutput("fill_count", 32'(count_o), 32'(i));
        end
        applyStimulus(1'b1, 5'd1, 32'd0, 1'b1, 5'd30, 32'hBAD, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("full_count", 32'(count_o), 32'd8);
        checkOutput("full_no_overflow_yet", 32'(overflow_o), 32'd0);
        applyStimulus(1'b1, 5'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        checkOutput("overflow_set", 32'(overflow_o), 32'd1);
        checkOutput("overflow_count", 32'(count_o), 32'd8);
        idleCycle();
        checkOutput("overflow_held", 32'(overflow_o), 32'd1);
        checkOutput("drain_head_x16", 32'(rf_waddr_o), 32'd16);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_we", 32'(rf_we_o), 32'd0);
        checkOutput("async_waddr", 32'(rf_waddr_o), 32'd0);
        checkOutput("async_wdata", rf_wdata_o, 32'd0);
        checkOutput("async_count", 32'(count_o), 32'd0);
        checkOutput("async_overflow", 32'(overflow_o), 32'd0);
        checkOutput("async_stall", 32'(stall_req_o), 32'd0);
        checkOutput("async_pend", 32'(rs_pend_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idleCycle();
        checkOutput("post_reset_count", 32'(count_o), 32'd0);
        checkOutput("post_reset_we", 32'(rf_we_o), 32'd0);
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
